// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 accumulator core.
// Opcodes, FSM state encoding and instruction field helpers.
package sap2_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] S_F_ADDR = 3'd0;
  localparam logic [2:0] S_F_MEM  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_E_ADDR = 3'd3;
  localparam logic [2:0] S_E_MEM  = 3'd4;
  localparam logic [2:0] S_E_ALU  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // Top nibble of a dw-bit instruction word.
  function automatic logic [3:0] op_field(
    input logic [31:0] ir,
    input int          dw
  );
    return ir[dw-1 -: 4];
  endfunction

  // Low aw bits of an instruction word, zero-extended.
  function automatic logic [31:0] arg_field(
    input logic [31:0] ir,
    input int          aw
  );
    return ir & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/sap2_alu.sv
// Combinational add/subtract unit with carry-out and zero detect.
// Ports: a, b operands; sub selects a+~b+1; sum, carry, zero results.
module sap2_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         zero
);

  logic [W-1:0] bx;
  logic [W:0]   r;

  // Subtract as two's complement add; carry=1 means no borrow.
  assign bx    = sub ? ~b : b;
  assign r     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
  assign sum   = r[W-1:0];
  assign carry = r[W];
  assign zero  = (r[W-1:0] == '0);

endmodule

// File: rtl/sap2_core.sv
// SAP-2 accumulator CPU with variable-length FSM and req/ack memory port.
// Ports: clk/clr_n, mem_* handshake, out_data/out_valid, halted, *_dbg state.
module sap2_core
  import sap2_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 clr_n,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-5:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 halted,
  output logic [DATA_W-5:0]    pc_dbg,
  output logic [DATA_W-1:0]    acc_dbg,
  output logic [1:0]           flags_dbg
);

  localparam int ADDR_W = DATA_W - 4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] ir;
  logic              cf;
  logic              zf;

  logic [31:0]       ir_w;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic              xfer;

  logic [DATA_W-1:0] alu_sum;
  logic              alu_c;
  logic              alu_z;

  assign ir_w    = 32'(ir);
  assign opcode  = op_field(ir_w, DATA_W);
  assign operand = ADDR_W'(arg_field(ir_w, ADDR_W));
  assign imm     = {4'b0000, operand};
  assign xfer    = mem_req & mem_ack;

  sap2_alu #(
    .W(DATA_W)
  ) u_alu (
    .a    (acc),
    .b    (b),
    .sub  (opcode == OP_SUB),
    .sum  (alu_sum),
    .carry(alu_c),
    .zero (alu_z)
  );

  assign mem_addr  = mar;
  assign mem_wdata = (mem_req && mem_we) ? acc : '0;
  assign halted    = (state == S_HALT);
  assign pc_dbg    = pc;
  assign acc_dbg   = acc;
  assign flags_dbg = {cf, zf};

  // mem_req/mem_we are registered: set on entry to a memory
  // state, cleared on the edge that completes the transfer.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_F_ADDR;
      pc        <= ADDR_W'(RESET_PC);
      mar       <= '0;
      acc       <= '0;
      b         <= '0;
      ir        <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_F_ADDR: begin
          mar     <= pc;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          state   <= S_F_MEM;
        end
        S_F_MEM: begin
          if (xfer) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_F_ADDR;
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              state <= S_E_ADDR;
            end
            OP_LDI: begin
              acc <= imm;
              zf  <= (operand == '0);
            end
            OP_JMP: pc <= operand;
            OP_JC: begin
              if (cf) pc <= operand;
            end
            OP_JZ: begin
              if (zf) pc <= operand;
            end
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HLT: state <= S_HALT;
            default: ;
          endcase
        end
        S_E_ADDR: begin
          mar     <= operand;
          mem_req <= 1'b1;
          mem_we  <= (opcode == OP_STA);
          state   <= S_E_MEM;
        end
        S_E_MEM: begin
          if (xfer) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_F_ADDR;
            unique case (opcode)
              OP_LDA: begin
                acc <= mem_rdata;
                zf  <= (mem_rdata == '0);
              end
              OP_ADD, OP_SUB: begin
                b     <= mem_rdata;
                state <= S_E_ALU;
              end
              default: ;
            endcase
          end
        end
        S_E_ALU: begin
          acc   <= alu_sum;
          cf    <= alu_c;
          zf    <= alu_z;
          state <= S_F_ADDR;
        end
        S_HALT: begin
          mem_req <= 1'b0;
          state   <= S_HALT;
        end
        default: state <= S_F_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_sap2_core.sv
// Directed self-checking bench for sap2_core (8-bit and 12-bit builds).
// Table of small programs plus hand sequences for timing and reset corners.
module tb_sap2_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;

  logic       req8, we8, ack8, ov8, h8;
  logic [3:0] addr8, pc8;
  logic [7:0] wd8, rd8, od8, acc8;
  logic [1:0] fl8;

  logic        req12, we12, ack12, ov12, h12;
  logic [7:0]  addr12, pc12;
  logic [11:0] wd12, rd12, od12, acc12;
  logic [1:0]  fl12;

  logic [7:0]  mem8 [16];
  logic [11:0] mem12 [256];

  int   wait_r, wait_w, blk;
  logic man_mode, man_ack;
  int   cnt8 = 0;
  int   pulses8 = 0;
  int   wr_n = 0;
  logic [3:0] wr_a = '0;
  logic [7:0] wr_d = '0;

  int total = 0;
  int bad = 0;

  sap2_core #(.DATA_W(8)) dut8 (
    .clk(clk), .clr_n(clr_n),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wd8), .mem_rdata(rd8), .mem_ack(ack8),
    .out_data(od8), .out_valid(ov8), .halted(h8),
    .pc_dbg(pc8), .acc_dbg(acc8), .flags_dbg(fl8)
  );

  sap2_core #(.DATA_W(12)) dut12 (
    .clk(clk), .clr_n(clr_n),
    .mem_req(req12), .mem_we(we12), .mem_addr(addr12),
    .mem_wdata(wd12), .mem_rdata(rd12), .mem_ack(ack12),
    .out_data(od12), .out_valid(ov12), .halted(h12),
    .pc_dbg(pc12), .acc_dbg(acc12), .flags_dbg(fl12)
  );

  assign rd8  = mem8[addr8];
  assign ack8 = man_mode ? man_ack :
                (req8 && int'(addr8) != blk &&
                 cnt8 == (we8 ? wait_w : wait_r));
  assign rd12  = mem12[addr12];
  assign ack12 = req12;

  always @(posedge clk) begin
    if (ov8) pulses8 <= pulses8 + 1;
    if (req8 && ack8) begin
      cnt8 <= 0;
      if (we8) begin
        wr_n <= wr_n + 1;
        wr_a <= addr8;
        wr_d <= wd8;
      end
    end else if (req8) begin
      cnt8 <= cnt8 + 1;
    end else begin
      cnt8 <= 0;
    end
  end

  typedef struct {
    logic [0:15][7:0] prog;
    int               wr;
    int               ww;
    logic [7:0]       acc;
    logic [1:0]       fl;
    logic [3:0]       pc;
    logic [7:0]       od;
    int               np;
  } vec_t;

  function automatic vec_t mk(
    input logic [0:15][7:0] p, input int wr, input int ww,
    input logic [7:0] a, input logic [1:0] f,
    input logic [3:0] pc, input logic [7:0] o, input int np
  );
    vec_t v;
    v.prog = p; v.wr = wr; v.ww = ww; v.acc = a;
    v.fl = f; v.pc = pc; v.od = o; v.np = np;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    man_mode = 1'b0;
    man_ack  = 1'b0;
    clr_n    = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic run8(input int limit);
    int n;
    n = 0;
    while (!h8 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic load8(input logic [0:15][7:0] p);
    for (int a = 0; a < 16; a++) mem8[a] = p[a];
  endtask

  vec_t vecs[12];

  initial begin
    int p0, w0, t0, t1, wcyc, stab, wdz, n;
    int tf[5];
    logic prev;

    clr_n = 1'b0; man_mode = 1'b0; man_ack = 1'b0;
    wait_r = 0; wait_w = 0; blk = -1;
    for (int a = 0; a < 256; a++) mem12[a] = '0;
    for (int a = 0; a < 16; a++) mem8[a] = '0;

    vecs[0] = mk({8'h09,8'h1A,8'hE0,8'hF0,8'h00,8'h00,8'h00,8'h00,
                  8'h00,8'h05,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00},
                 0, 0, 8'h08, 2'b00, 4'h4, 8'h08, 1);
    vecs[1] = mk(vecs[0].prog, 2, 0, 8'h08, 2'b00, 4'h4, 8'h08, 1);
    vecs[2] = mk({8'h42,8'h2F,8'h65,8'hF0,8'h00,8'hF0,8'h00,8'h00,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h03},
                 0, 0, 8'hFF, 2'b00, 4'h4, 8'h00, 0);
    vecs[3] = mk({8'h40,8'h78,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                  8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                 0, 0, 8'h00, 2'b01, 4'h9, 8'h00, 0);
    vecs[4] = mk({8'h6E,8'h0D,8'h1D,8'h5F,8'h00,8'h00,8'h00,8'h00,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF,8'hF0,8'h80},
                 0, 0, 8'hFE, 2'b10, 4'hF, 8'h00, 0);
    vecs[5] = mk({8'h0E,8'h1D,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'hFF,8'h00},
                 0, 0, 8'h00, 2'b11, 4'h3, 8'h00, 0);
    vecs[6] = mk({8'h0E,8'h1D,8'h66,8'hF0,8'h00,8'h00,8'hE0,8'hF0,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'hFF,8'h00},
                 0, 0, 8'h00, 2'b11, 4'h8, 8'h00, 1);
    vecs[7] = mk({8'h45,8'h2F,8'hE0,8'hF0,8'h00,8'h00,8'h00,8'h00,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h03},
                 0, 0, 8'h02, 2'b10, 4'h4, 8'h02, 1);
    vecs[8] = mk({8'h47,8'h83,8'h9F,8'hA0,8'hBF,8'hC0,8'hD1,8'hF0,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                 0, 0, 8'h07, 2'b00, 4'h8, 8'h00, 0);
    vecs[9] = mk({8'h41,8'h75,8'hF0,8'h00,8'h00,8'hF0,8'h00,8'h00,
                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                 0, 0, 8'h01, 2'b00, 4'h3, 8'h00, 0);
    vecs[10] = mk({8'h5C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                   8'h00,8'h00,8'h00,8'h00,8'h43,8'hF0,8'h00,8'h00},
                  0, 0, 8'h03, 2'b00, 4'hE, 8'h00, 0);
    vecs[11] = mk({8'h0D,8'h3E,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,
                   8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  1, 3, 8'h00, 2'b01, 4'h3, 8'h00, 0);

    do_reset();
    #1;
    chk("rst_req", req8, 0);
    chk("rst_halted", h8, 0);
    chk("rst_pc", pc8, 0);
    chk("rst_acc", acc8, 0);
    chk("rst_out", od8, 0);
    chk("rst_flags", fl8, 0);

    for (int i = 0; i < 12; i++) begin
      load8(vecs[i].prog);
      wait_r = vecs[i].wr;
      wait_w = vecs[i].ww;
      do_reset();
      p0 = pulses8;
      run8(400);
      chk($sformatf("v%0d_halted", i), h8, 1);
      chk($sformatf("v%0d_acc", i), acc8, vecs[i].acc);
      chk($sformatf("v%0d_flags", i), fl8, vecs[i].fl);
      chk($sformatf("v%0d_pc", i), pc8, vecs[i].pc);
      chk($sformatf("v%0d_out", i), od8, vecs[i].od);
      chk($sformatf("v%0d_pulses", i), pulses8 - p0, vecs[i].np);
      chk($sformatf("v%0d_req_in_halt", i), req8, 0);
    end

    // STA with a 3-cycle write wait: 8-cycle instruction.
    load8({8'h0D,8'h3E,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,
           8'h00,8'h00,8'h00,8'h00,8'h00,8'h5A,8'h00,8'h00});
    wait_r = 0; wait_w = 3;
    do_reset();
    w0 = wr_n; t0 = -1; t1 = -1;
    wcyc = 0; stab = 0; wdz = 0; prev = 1'b0; n = 0;
    while (!h8 && n < 200) begin
      @(negedge clk);
      n++;
      if (req8 && !prev && !we8) begin
        if (addr8 == 4'h1 && t0 < 0) t0 = n;
        if (addr8 == 4'h2 && t1 < 0) t1 = n;
      end
      if (req8 && we8) begin
        wcyc++;
        if (addr8 !== 4'hE || wd8 !== 8'h5A) stab++;
      end else if (wd8 !== 8'h00) begin
        wdz++;
      end
      prev = req8;
    end
    chk("sta_len", t1 - t0, 8);
    chk("sta_wr_cycles", wcyc, 4);
    chk("sta_stable", stab, 0);
    chk("sta_wdata_zero", wdz, 0);
    chk("sta_writes", wr_n - w0, 1);
    chk("sta_addr", wr_a, 4'hE);
    chk("sta_data", wr_d, 8'h5A);

    // Zero-wait latencies: LDA 5, ADD 6, LDI 3, NOP 3.
    load8({8'h0D,8'h1D,8'h41,8'h80,8'hF0,8'h00,8'h00,8'h00,
           8'h00,8'h00,8'h00,8'h00,8'h00,8'h07,8'h00,8'h00});
    wait_r = 0; wait_w = 0;
    do_reset();
    for (int k = 0; k < 5; k++) tf[k] = -1;
    prev = 1'b0; n = 0;
    while (!h8 && n < 200) begin
      @(negedge clk);
      n++;
      if (req8 && !prev && !we8 && addr8 < 4'h5)
        if (tf[addr8] < 0) tf[addr8] = n;
      prev = req8;
    end
    chk("lat_lda", tf[1] - tf[0], 5);
    chk("lat_add", tf[2] - tf[1], 6);
    chk("lat_ldi", tf[3] - tf[2], 3);
    chk("lat_nop", tf[4] - tf[3], 3);
    chk("lat_acc", acc8, 8'h01);

    // Reset while a data read waits for ack; a late ack is ignored.
    load8({8'h0D,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
           8'h00,8'h00,8'h00,8'h00,8'h00,8'h33,8'h00,8'h00});
    blk = 13;
    do_reset();
    n = 0;
    while (!(req8 && addr8 == 4'hD) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_emem", req8 && addr8 == 4'hD, 1);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_req_drop", req8, 0);
    chk("mid_we_drop", we8, 0);
    chk("mid_pc", pc8, 0);
    chk("mid_acc", acc8, 0);
    @(negedge clk);
    blk = -1;
    man_mode = 1'b1;
    man_ack = 1'b1;
    clr_n = 1'b1;
    @(negedge clk);
    man_mode = 1'b0;
    man_ack = 1'b0;
    chk("mid_acc_after", acc8, 0);
    chk("mid_restart_req", req8, 1);
    chk("mid_restart_addr", addr8, 0);
    run8(200);
    chk("mid_final_acc", acc8, 8'h33);
    chk("mid_final_pc", pc8, 4'h2);

    // 12-bit build: 0xFFF + 0x001 wraps to zero with carry.
    mem12[0] = 12'h010;
    mem12[1] = 12'h111;
    mem12[2] = 12'hF00;
    mem12[16] = 12'hFFF;
    mem12[17] = 12'h001;
    do_reset();
    n = 0;
    while (!h12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("w12_halted", h12, 1);
    chk("w12_acc", acc12, 12'h000);
    chk("w12_flags", fl12, 2'b11);
    chk("w12_pc", pc12, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
